// File: rtl/core_mem_pkg.sv
// Shared types for the core memory request bus: bus widths, request record, responder states.
// No logic; widths here fix the port sizes of every block on the bus.
// Imported by the responder top and its request checker.
package core_mem_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;

  // One request as presented on the bus while mem_req is high
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  wen;
    logic [MEM_STRB_W-1:0] strb;
    logic [MEM_DATA_W-1:0] wdata;
    logic                  rtype;
  } mem_req_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/core_mem_req_checker.sv
// Watches a stalled request and flags any change of its payload or an early drop of req.
// Latency: proto_err_o rises on the clock edge that ends the offending cycle.
// Backpressure: none; purely observes req/gnt, never stalls the bus.
module core_mem_req_checker
  import core_mem_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     req_i,
  input  logic     gnt_i,
  input  mem_req_t req_dat_i,
  output logic     proto_err_o
);

  logic                  stalled_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic                  wen_q;
  logic [MEM_STRB_W-1:0] strb_q;
  logic [MEM_DATA_W-1:0] wdata_q;
  logic                  proto_err_q;
  logic                  changed;
  logic                  violation;

  // rtype is informational and deliberately not part of the hold check
  logic unused_rtype;
  assign unused_rtype = req_dat_i.rtype;

  // A request that was stalled last cycle must still be present, unchanged
  always_comb begin
    changed   = (req_dat_i.addr  != addr_q)  ||
                (req_dat_i.wen   != wen_q)   ||
                (req_dat_i.strb  != strb_q)  ||
                (req_dat_i.wdata != wdata_q);
    violation = stalled_q && (!req_i || changed);
  end

  // Capture the payload of every stalled cycle; the error flag is sticky until reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stalled_q   <= 1'b0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      strb_q      <= '0;
      wdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      stalled_q <= req_i && !gnt_i;
      if (req_i && !gnt_i) begin
        addr_q  <= req_dat_i.addr;
        wen_q   <= req_dat_i.wen;
        strb_q  <= req_dat_i.strb;
        wdata_q <= req_dat_i.wdata;
      end
      if (violation) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  assign proto_err_o = proto_err_q;

endmodule

// File: rtl/core_mem_responder.sv
// Target end of the core memory bus: wait states, window/permission check, SRAM front end.
// Latency: grant after WAIT_CYCLES stall cycles; rdata/err exactly one cycle after grant.
// Backpressure: mem_gnt is withheld while the wait counter runs; responses cannot be stalled.
module core_mem_responder
  import core_mem_pkg::*;
#(
  parameter logic [MEM_ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
  parameter int                    SRAM_DEPTH  = 1024,
  parameter int                    WAIT_CYCLES = 0,
  parameter bit                    READ_ONLY   = 1'b0,
  localparam int                   IDX_W       = $clog2(SRAM_DEPTH)
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  mem_req,
  input  logic                  mem_rtype,
  input  logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic                  mem_wen,
  input  logic [MEM_STRB_W-1:0] mem_strb,
  input  logic [MEM_DATA_W-1:0] mem_wdata,
  output logic                  mem_gnt,
  output logic                  mem_err,
  output logic [MEM_DATA_W-1:0] mem_rdata,
  output logic                  sram_cen,
  output logic                  sram_wen,
  output logic [IDX_W-1:0]      sram_addr,
  output logic [MEM_STRB_W-1:0] sram_strb,
  output logic [MEM_DATA_W-1:0] sram_wdata,
  input  logic [MEM_DATA_W-1:0] sram_rdata,
  output logic                  proto_err
);

  localparam logic [3:0]            WAIT_LAST    = 4'(WAIT_CYCLES);
  localparam logic [MEM_ADDR_W-1:0] WINDOW_BYTES = MEM_ADDR_W'(SRAM_DEPTH * 8);

  rsp_state_e            state_q;
  logic [3:0]            wait_ctr_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic                  rsp_read_q;
  logic [MEM_ADDR_W-1:0] offset;
  logic                  in_range;
  logic                  acc_err;
  logic                  gnt;
  logic                  access;
  mem_req_t              req_dat;

  assign req_dat = '{addr: mem_addr, wen: mem_wen, strb: mem_strb,
                     wdata: mem_wdata, rtype: mem_rtype};

  // Decode: subtraction wraps below BASE_ADDR so such addresses fall outside the window.
  // Grant is masked by reset so every output reads 0 while reset is held.
  always_comb begin
    offset   = mem_addr - BASE_ADDR;
    in_range = offset < WINDOW_BYTES;
    acc_err  = !in_range || (READ_ONLY && mem_wen);
    gnt      = !g_reset && mem_req && (wait_ctr_q == WAIT_LAST);
    access   = gnt && !acc_err;
  end

  assign mem_gnt    = gnt;
  assign sram_cen   = access;
  assign sram_wen   = access && mem_wen;
  assign sram_addr  = access ? offset[IDX_W+2:3] : '0;
  assign sram_strb  = access ? mem_strb  : '0;
  assign sram_wdata = access ? mem_wdata : '0;

  // Wait-state FSM: count stalled cycles of a held request, restart on grant or dropped req
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q    <= IDLE;
      wait_ctr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_req && !gnt) begin
            state_q    <= WAIT;
            wait_ctr_q <= wait_ctr_q + 4'd1;
          end
        end
        WAIT: begin
          if (!mem_req || gnt) begin
            state_q    <= IDLE;
            wait_ctr_q <= '0;
          end else begin
            wait_ctr_q <= wait_ctr_q + 4'd1;
          end
        end
        default: begin
          state_q    <= IDLE;
          wait_ctr_q <= '0;
        end
      endcase
    end
  end

  // Response bookkeeping for the grant of this cycle, presented on the next one
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_read_q  <= 1'b0;
    end else begin
      rsp_valid_q <= gnt;
      rsp_err_q   <= gnt && acc_err;
      rsp_read_q  <= gnt && !mem_wen;
    end
  end

  assign mem_err   = rsp_valid_q && rsp_err_q;
  assign mem_rdata = (rsp_valid_q && !rsp_err_q && rsp_read_q) ? sram_rdata : '0;

  core_mem_req_checker u_checker (
    .clk_i       (g_clk),
    .rst_i       (g_reset),
    .req_i       (mem_req),
    .gnt_i       (gnt),
    .req_dat_i   (req_dat),
    .proto_err_o (proto_err)
  );

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench: three responders (0 wait, 3 wait, 2 wait + read-only), each with its own SRAM.
module tb_core_mem_responder;

  localparam int N = 3;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        req   [N];
  logic        rtype [N];
  logic        wen   [N];
  logic [31:0] addr  [N];
  logic [7:0]  strb  [N];
  logic [63:0] wdata [N];
  logic        gnt   [N];
  logic        err   [N];
  logic [63:0] rdata [N];
  logic        cen   [N];
  logic        swen  [N];
  logic [9:0]  saddr [N];
  logic [7:0]  sstrb [N];
  logic [63:0] swdata[N];
  logic        perr  [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 g_clk = ~g_clk;

  function automatic logic [63:0] init_word(int k);
    return {16'hC0DE, 16'(k), 16'h5A5A, 16'(k)};
  endfunction

  for (genvar g = 0; g < N; g++) begin : gi
    logic [63:0] mem [1024];
    logic [63:0] sram_rd;

    core_mem_responder #(
      .BASE_ADDR   (32'h1000_0000),
      .SRAM_DEPTH  (1024),
      .WAIT_CYCLES (g == 0 ? 0 : (g == 1 ? 3 : 2)),
      .READ_ONLY   (g == 2)
    ) dut (
      .g_clk      (g_clk),
      .g_reset    (g_reset),
      .mem_req    (req[g]),
      .mem_rtype  (rtype[g]),
      .mem_addr   (addr[g]),
      .mem_wen    (wen[g]),
      .mem_strb   (strb[g]),
      .mem_wdata  (wdata[g]),
      .mem_gnt    (gnt[g]),
      .mem_err    (err[g]),
      .mem_rdata  (rdata[g]),
      .sram_cen   (cen[g]),
      .sram_wen   (swen[g]),
      .sram_addr  (saddr[g]),
      .sram_strb  (sstrb[g]),
      .sram_wdata (swdata[g]),
      .sram_rdata (sram_rd),
      .proto_err  (perr[g])
    );

    // Synchronous single-port SRAM model with byte strobes
    initial begin
      for (int k = 0; k < 1024; k++) mem[k] = init_word(k);
      forever begin
        @(posedge g_clk);
        if (cen[g]) begin
          if (swen[g]) begin
            for (int b = 0; b < 8; b++)
              if (sstrb[g][b]) mem[saddr[g]][8*b +: 8] = swdata[g][8*b +: 8];
          end else begin
            sram_rd <= mem[saddr[g]];
          end
        end
      end
    end
  end

  typedef struct {
    int          inst;
    logic        rq;
    logic        we;
    logic [31:0] a;
    logic [7:0]  s;
    logic [63:0] d;
    logic        e_gnt;
    logic        e_cen;
    logic        e_err;
    logic [63:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int inst, logic rq, logic we, logic [31:0] a, logic [7:0] s,
                              logic [63:0] d, logic eg, logic ec, logic ee, logic [63:0] er);
    vec_t v;
    v.inst = inst; v.rq = rq; v.we = we; v.a = a; v.s = s; v.d = d;
    v.e_gnt = eg; v.e_cen = ec; v.e_err = ee; v.e_rdata = er;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b0; rtype[i] = 1'b0; wen[i] = 1'b0;
      addr[i] = '0; strb[i] = '0; wdata[i] = '0;
    end
  endtask

  task automatic set_in(int i, logic rq, logic we, logic [31:0] a, logic [7:0] s, logic [63:0] d);
    req[i] = rq; wen[i] = we; addr[i] = a; strb[i] = s; wdata[i] = d; rtype[i] = (i == 1);
  endtask

  task automatic next_cycle();
    @(posedge g_clk);
    #1;
  endtask

  localparam logic [63:0] W0  = 64'hC0DE0000_5A5A0000;
  localparam logic [63:0] W1  = 64'hC0DE0001_5A5A0001;
  localparam logic [63:0] W2  = 64'hC0DE0002_5A5A0002;
  localparam logic [63:0] W3  = 64'hC0DE0003_5A5A0003;
  localparam logic [63:0] W1M = 64'hC0DE0001_11223344;

  initial begin
    // ---- reset state, with a would-be zero-wait request present on instance 0
    g_reset = 1'b1;
    idle_all();
    set_in(0, 1'b1, 1'b0, 32'h1000_0000, 8'h00, 64'h0);
    #2;
    check("rst gnt0", 64'(gnt[0]), 64'd0);
    check("rst cen0", 64'(cen[0]), 64'd0);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst err%0d", i), 64'(err[i]), 64'd0);
      check($sformatf("rst rdata%0d", i), rdata[i], 64'd0);
      check($sformatf("rst perr%0d", i), 64'(perr[i]), 64'd0);
    end
    next_cycle();
    g_reset = 1'b0;
    idle_all();

    // ---- instance 0: zero wait states
    vecs.push_back(mk(0, 1, 0, 32'h1000_0000, 8'h00, 64'h0, 1, 1, 0, 64'h0));
    vecs.push_back(mk(0, 1, 0, 32'h1000_0008, 8'h00, 64'h0, 1, 1, 0, W0));
    vecs.push_back(mk(0, 1, 1, 32'h1000_0008, 8'h0F, 64'hAABBCCDD_11223344, 1, 1, 0, W1));
    vecs.push_back(mk(0, 1, 0, 32'h1000_0008, 8'h00, 64'h0, 1, 1, 0, 64'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0FFF_FFF8, 8'h00, 64'h0, 1, 0, 0, W1M));
    vecs.push_back(mk(0, 1, 0, 32'h1000_2000, 8'h00, 64'h0, 1, 0, 1, 64'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         8'h00, 64'h0, 0, 0, 1, 64'h0));
    vecs.push_back(mk(0, 1, 1, 32'h1000_0010, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 0, 64'h0));
    vecs.push_back(mk(0, 1, 0, 32'h1000_0015, 8'h00, 64'h0, 1, 1, 0, 64'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,         8'h00, 64'h0, 0, 0, 0, W2));
    vecs.push_back(mk(0, 0, 0, 32'h0,         8'h00, 64'h0, 0, 0, 0, 64'h0));
    // ---- instance 1: three wait states, two requests back to back
    vecs.push_back(mk(1, 1, 0, 32'h1000_0010, 8'h00, 64'h0, 0, 0, 0, 64'h0));
    vecs.push_back(mk(1, 1, 0, 32'h1000_0010, 8'h00, 64'h0, 0, 0, 0, 64'h0));
    vecs.push_back(mk(1, 1, 0, 32'h1000_0010, 8'h00, 64'h0, 0, 0, 0, 64'h0));
    vecs.push_back(mk(1, 1, 0, 32'h1000_0010, 8'h00, 64'h0, 1, 1, 0, 64'h0));
    vecs.push_back(mk(1, 1, 0, 32'h1000_0000, 8'h00, 64'h0, 0, 0, 0, W2));
    vecs.push_back(mk(1, 1, 0, 32'h1000_0000, 8'h00, 64'h0, 0, 0, 0, 64'h0));
    vecs.push_back(mk(1, 1, 0, 32'h1000_0000, 8'h00, 64'h0, 0, 0, 0, 64'h0));
    vecs.push_back(mk(1, 1, 0, 32'h1000_0000, 8'h00, 64'h0, 1, 1, 0, 64'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,         8'h00, 64'h0, 0, 0, 0, W0));
    // ---- instance 2: two wait states, read-only; write refused then old data read back
    vecs.push_back(mk(2, 1, 1, 32'h1000_0018, 8'hFF, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 64'h0));
    vecs.push_back(mk(2, 1, 1, 32'h1000_0018, 8'hFF, 64'h1234_5678_9ABC_DEF0, 0, 0, 0, 64'h0));
    vecs.push_back(mk(2, 1, 1, 32'h1000_0018, 8'hFF, 64'h1234_5678_9ABC_DEF0, 1, 0, 0, 64'h0));
    vecs.push_back(mk(2, 0, 0, 32'h0,         8'h00, 64'h0, 0, 0, 1, 64'h0));
    vecs.push_back(mk(2, 1, 0, 32'h1000_0018, 8'h00, 64'h0, 0, 0, 0, 64'h0));
    vecs.push_back(mk(2, 1, 0, 32'h1000_0018, 8'h00, 64'h0, 0, 0, 0, 64'h0));
    vecs.push_back(mk(2, 1, 0, 32'h1000_0018, 8'h00, 64'h0, 1, 1, 0, 64'h0));
    vecs.push_back(mk(2, 0, 0, 32'h0,         8'h00, 64'h0, 0, 0, 0, W3));

    foreach (vecs[n]) begin
      idle_all();
      set_in(vecs[n].inst, vecs[n].rq, vecs[n].we, vecs[n].a, vecs[n].s, vecs[n].d);
      @(negedge g_clk);
      check($sformatf("v%0d gnt", n),   64'(gnt[vecs[n].inst]), 64'(vecs[n].e_gnt));
      check($sformatf("v%0d cen", n),   64'(cen[vecs[n].inst]), 64'(vecs[n].e_cen));
      check($sformatf("v%0d err", n),   64'(err[vecs[n].inst]), 64'(vecs[n].e_err));
      check($sformatf("v%0d rdata", n), rdata[vecs[n].inst],    vecs[n].e_rdata);
      next_cycle();
    end
    idle_all();
    for (int i = 0; i < N; i++) check($sformatf("clean perr%0d", i), 64'(perr[i]), 64'd0);

    // ---- instance 1: req dropped mid-stall -> sticky error, counter restarts
    for (int c = 0; c < 2; c++) begin
      set_in(1, 1'b1, 1'b0, 32'h1000_0000, 8'h00, 64'h0);
      @(negedge g_clk);
      check($sformatf("drop stall%0d gnt", c), 64'(gnt[1]), 64'd0);
      next_cycle();
    end
    idle_all();
    @(negedge g_clk);
    check("drop perr same cycle", 64'(perr[1]), 64'd0);
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      set_in(1, 1'b1, 1'b0, 32'h1000_0008, 8'h00, 64'h0);
      @(negedge g_clk);
      check($sformatf("restart c%0d gnt", c), 64'(gnt[1]), 64'(c == 3));
      check($sformatf("restart c%0d perr", c), 64'(perr[1]), 64'd1);
      next_cycle();
    end
    idle_all();
    @(negedge g_clk);
    check("restart rdata", rdata[1], W1);
    next_cycle();

    // ---- instance 2: address changed while stalled
    set_in(2, 1'b1, 1'b0, 32'h1000_0020, 8'h00, 64'h0);
    @(negedge g_clk);
    check("chg c0 gnt", 64'(gnt[2]), 64'd0);
    next_cycle();
    set_in(2, 1'b1, 1'b0, 32'h1000_0028, 8'h00, 64'h0);
    @(negedge g_clk);
    check("chg c1 perr", 64'(perr[2]), 64'd0);
    next_cycle();
    @(negedge g_clk);
    check("chg c2 perr", 64'(perr[2]), 64'd1);
    next_cycle();
    idle_all();
    @(negedge g_clk);
    check("chg hold perr", 64'(perr[2]), 64'd1);
    next_cycle();

    // ---- reset asserted mid-stall, with a zero-wait write also offered on instance 0
    set_in(2, 1'b1, 1'b0, 32'h1000_0000, 8'h00, 64'h0);
    next_cycle();
    set_in(0, 1'b1, 1'b1, 32'h1000_0030, 8'hFF, 64'hDEAD_BEEF_CAFE_F00D);
    g_reset = 1'b1;
    #1;
    check("mrst gnt2",   64'(gnt[2]),  64'd0);
    check("mrst perr2",  64'(perr[2]), 64'd0);
    check("mrst perr1",  64'(perr[1]), 64'd0);
    check("mrst gnt0",   64'(gnt[0]),  64'd0);
    check("mrst cen0",   64'(cen[0]),  64'd0);
    check("mrst swen0",  64'(swen[0]), 64'd0);
    check("mrst saddr0", 64'(saddr[0]), 64'd0);
    check("mrst sstrb0", 64'(sstrb[0]), 64'd0);
    check("mrst swdat0", swdata[0],     64'd0);
    check("mrst err2",   64'(err[2]),   64'd0);
    check("mrst rdata2", rdata[2],      64'd0);
    next_cycle();
    g_reset = 1'b0;
    idle_all();
    next_cycle();

    // ---- after reset: memory contents survive, zero-wait read works again
    set_in(0, 1'b1, 1'b0, 32'h1000_0008, 8'h00, 64'h0);
    @(negedge g_clk);
    check("post gnt0", 64'(gnt[0]), 64'd1);
    next_cycle();
    idle_all();
    @(negedge g_clk);
    check("post rdata0", rdata[0], W1M);
    check("post perr2",  64'(perr[2]), 64'd0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_mem_responder.md
Name: core_mem_responder

Overview:
- Responder (target) end of the core memory request bus (req/gnt, one-cycle-later rdata/err) used by the fetch and memory pipeline stages.
- Accepts requests, inserts programmable wait states, and checks the address window and write permission.
- Drives a single-port synchronous SRAM and returns each response exactly one cycle after grant.
- Used as the instruction/data memory model in the core testbench and as the on-chip TCM front end.

Parameters:
- BASE_ADDR, 'h10000000, first byte address of the window; must be 8-byte aligned.
- SRAM_DEPTH, 1024, number of 64-bit words; power of two.
- WAIT_CYCLES, 0, stall cycles inserted before each grant (0..15).
- READ_ONLY, 0, when 1 any write request returns an error.

Ports:
- g_clk  in  1  global clock
- g_reset  in  1  asynchronous active-high reset
- mem_req  in  1  request valid
- mem_rtype  in  1  0=data, 1=instruction (informational only)
- mem_addr  in  MEM_ADDR_W  byte address
- mem_wen  in  1  write enable
- mem_strb  in  MEM_STRB_W  write byte strobes
- mem_wdata  in  MEM_DATA_W  write data
- mem_gnt  out  1  request accepted this cycle
- mem_err  out  1  response error; valid the cycle after grant
- mem_rdata  out  MEM_DATA_W  response data; valid the cycle after grant
- sram_cen  out  1  SRAM access enable
- sram_wen  out  1  SRAM write
- sram_addr  out  clog2(SRAM_DEPTH)  SRAM word index
- sram_strb  out  MEM_STRB_W  SRAM byte write enables
- sram_wdata  out  MEM_DATA_W  SRAM write data
- sram_rdata  in  MEM_DATA_W  SRAM read data, one cycle after sram_cen
- proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE, wait_ctr=0, rsp_valid=0, rsp_err=0, proto_err=0. While reset is asserted, all outputs are 0.
- FSM states:
  - IDLE: on mem_req, go to WAIT if WAIT_CYCLES>0; otherwise grant in the same cycle.
  - WAIT: wait_ctr increments each cycle that mem_req is held. When wait_ctr==WAIT_CYCLES, mem_gnt=1, wait_ctr clears, and the next state is IDLE.
  - mem_gnt is combinational: mem_req && (wait_ctr==WAIT_CYCLES).
  - With WAIT_CYCLES=0, back-to-back grants occur every cycle.
- Address decode: in_range = (mem_addr - BASE_ADDR) < SRAM_DEPTH*8, computed in MEM_ADDR_W bits so addresses below BASE wrap and fail. Index = (mem_addr - BASE_ADDR) >> 3, and low 3 address bits are ignored.
- Access error = !in_range || (READ_ONLY && mem_wen).
- Grant cycle without error: sram_cen=1, sram_wen=mem_wen, sram_addr=index, sram_strb=mem_strb, sram_wdata=mem_wdata.
- Grant cycle with error: sram_cen=0; no SRAM access.
- Response: registered rsp_valid<=grant and rsp_err<=access error.
  - mem_err = rsp_valid && rsp_err.
  - mem_rdata = sram_rdata when rsp_valid && !rsp_err && it was a read; otherwise 0.
  - Latency from grant to response is exactly 1 cycle, independent of WAIT_CYCLES.
- A response cycle and a new grant may coincide; the response belongs to the previous grant.
- Protocol check: while mem_req && !mem_gnt, addr/wen/strb/wdata must hold their values.
  - A change in any of them, or mem_req dropping before gnt, sets proto_err (cleared only by reset).
  - A dropped req also clears wait_ctr and returns the FSM to IDLE.
- A write with mem_strb==0 is legal: SRAM access is issued with all strobes low.

Decomposition:
- Shared package core_mem_pkg: MEM_ADDR_W/MEM_DATA_W/MEM_STRB_W, a request struct {addr,wen,strb,wdata,rtype}, and an enum for the responder states {IDLE, WAIT}.
- One sub-module: core_mem_req_checker (holds the last stalled request, generates proto_err).
- The SRAM is external to this block.

Test Plan:
- WAIT_CYCLES=0, reads at 0x10000000 then 0x10000008 in consecutive cycles -> gnt high both cycles; rdata = word0 then word1 on the following cycles; err=0.
- WAIT_CYCLES=3, read 0x10000010 held -> gnt on the 4th cycle of req; rdata = word2 exactly one cycle later.
- Write 0x10000008, strb=0x0F, wdata=0xAABBCCDD11223344, then read the same address -> rdata low 4 bytes = 0x11223344, upper bytes unchanged.
- Read 0x0FFFFFF8 and read BASE+SRAM_DEPTH*8 -> gnt, then err=1 and rdata=0; sram_cen never asserted.
- READ_ONLY=1, write to an in-range address -> err=1, no SRAM write, and the following read returns the old data.
- WAIT_CYCLES=2, change mem_addr while stalled -> proto_err rises and stays high; assert g_reset mid-stall -> all outputs 0 immediately and proto_err cleared.
